// File: rtl/tennis_game.sv
// tennis_game: LED tennis with debounced buttons, a speed-up ball tick,
// serve handling and per-player scoring. Left end is pos N_LEDS-1, right end is pos 0.
module tennis_game #(
  parameter int N_LEDS          = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 25000000,
  parameter int MIN_DIV         = 5000000,
  parameter int SPEEDUP_STEP    = 2500000,
  parameter int SCORE_W         = 4,
  parameter int WIN_SCORE       = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left_btn,
  input  logic               right_btn,
  output logic [N_LEDS-1:0]  ball,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               point,
  output logic               game_over
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic [POS_W-1:0]   POS_LEFT  = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0]   POS_RIGHT = '0;
  localparam logic [DIV_W-1:0]   DIV_SERVE = DIV_W'(TICK_DIV);
  localparam logic [DIV_W-1:0]   DIV_MIN   = DIV_W'(MIN_DIV);
  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {SERVE_L, SERVE_R, MOVE_L, MOVE_R, OVER} state_t;

  // Button path, index 1 = left, index 0 = right
  logic [1:0]       btn_sync1;
  logic [1:0]       btn_sync2;
  logic [1:0]       btn_deb;
  logic [1:0]       btn_press;
  logic [DEB_W-1:0] deb_cnt [2];

  logic left_press;
  logic right_press;

  state_t           state, state_next;
  logic [POS_W-1:0] pos, pos_next;
  logic [DIV_W-1:0] cur_div, div_next, div_fast, div_slack;
  logic [DIV_W-1:0] tick_cnt, tick_cnt_next;
  logic             hit, hit_next;
  logic [SCORE_W-1:0] score_l_next, score_r_next;
  logic [SCORE_W-1:0] score_left_inc, score_right_inc;
  logic             point_next;
  logic [N_LEDS-1:0] ball_next;
  logic             game_over_next;
  logic             moving;
  logic             tick;

  assign left_press  = btn_press[1];
  assign right_press = btn_press[0];

  assign moving = (state == MOVE_L) || (state == MOVE_R);
  assign tick   = moving && (tick_cnt == cur_div - DIV_W'(1));

  assign score_left_inc  = (score_left  == '1) ? score_left  : score_left  + SCORE_W'(1);
  assign score_right_inc = (score_right == '1) ? score_right : score_right + SCORE_W'(1);

  // Speed-up after a return, clamped so the period never drops below MIN_DIV
  assign div_slack = cur_div - DIV_MIN;
  assign div_fast  = (32'(div_slack) > 32'(SPEEDUP_STEP)) ?
                     cur_div - DIV_W'(SPEEDUP_STEP) : DIV_MIN;

  // Two-flop synchroniser for the raw asynchronous buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_sync1 <= '0;
      btn_sync2 <= '0;
    end else begin
      btn_sync1 <= {left_btn, right_btn};
      btn_sync2 <= btn_sync1;
    end
  end

  // Accept a new level only after it has been stable long enough; pulse on rising acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_deb    <= '0;
      btn_press  <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_sync2[i] != btn_deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            btn_deb[i]   <= btn_sync2[i];
            btn_press[i] <= btn_sync2[i];
            deb_cnt[i]   <= '0;
          end else begin
            btn_press[i] <= 1'b0;
            deb_cnt[i]   <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          btn_press[i] <= 1'b0;
          deb_cnt[i]   <= '0;
        end
      end
    end
  end

  // Game state register together with the registered datapath and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SERVE_L;
      pos         <= POS_LEFT;
      cur_div     <= DIV_SERVE;
      tick_cnt    <= '0;
      hit         <= 1'b0;
      score_left  <= '0;
      score_right <= '0;
      point       <= 1'b0;
      ball        <= {1'b1, {(N_LEDS-1){1'b0}}};
      game_over   <= 1'b0;
    end else begin
      state       <= state_next;
      pos         <= pos_next;
      cur_div     <= div_next;
      tick_cnt    <= tick_cnt_next;
      hit         <= hit_next;
      score_left  <= score_l_next;
      score_right <= score_r_next;
      point       <= point_next;
      ball        <= ball_next;
      game_over   <= game_over_next;
    end
  end

  // Next state: serves, ball stepping, returns via the hit latch, and scoring on a miss
  always_comb begin
    state_next    = state;
    pos_next      = pos;
    div_next      = cur_div;
    hit_next      = hit;
    score_l_next  = score_left;
    score_r_next  = score_right;
    point_next    = 1'b0;
    tick_cnt_next = '0;
    case (state)
      SERVE_L: begin
        if (left_press) state_next = MOVE_R;
      end
      SERVE_R: begin
        if (right_press) state_next = MOVE_L;
      end
      MOVE_R: begin
        tick_cnt_next = tick ? '0 : tick_cnt + DIV_W'(1);
        if ((pos == POS_RIGHT) && right_press && !tick) hit_next = 1'b1;
        if (tick) begin
          if (pos != POS_RIGHT) begin
            pos_next = pos - POS_W'(1);
          end else if (hit) begin
            state_next = MOVE_L;
            pos_next   = POS_RIGHT + POS_W'(1);
            hit_next   = 1'b0;
            div_next   = div_fast;
          end else begin
            hit_next     = 1'b0;
            div_next     = DIV_SERVE;
            point_next   = 1'b1;
            pos_next     = POS_LEFT;
            score_l_next = score_left_inc;
            state_next   = (score_left_inc == WIN) ? OVER : SERVE_L;
          end
        end
      end
      MOVE_L: begin
        tick_cnt_next = tick ? '0 : tick_cnt + DIV_W'(1);
        if ((pos == POS_LEFT) && left_press && !tick) hit_next = 1'b1;
        if (tick) begin
          if (pos != POS_LEFT) begin
            pos_next = pos + POS_W'(1);
          end else if (hit) begin
            state_next = MOVE_R;
            pos_next   = POS_LEFT - POS_W'(1);
            hit_next   = 1'b0;
            div_next   = div_fast;
          end else begin
            hit_next     = 1'b0;
            div_next     = DIV_SERVE;
            point_next   = 1'b1;
            pos_next     = POS_RIGHT;
            score_r_next = score_right_inc;
            state_next   = (score_right_inc == WIN) ? OVER : SERVE_R;
          end
        end
      end
      OVER: begin
        state_next = OVER;
      end
      default: begin
        state_next = SERVE_L;
        pos_next   = POS_LEFT;
      end
    endcase
    if (state_next != state) tick_cnt_next = '0;
  end

  // Output decode: one-hot ball from the next position, all LEDs lit once the game is over
  always_comb begin
    ball_next      = N_LEDS'(1) << pos_next;
    game_over_next = 1'b0;
    if (state_next == OVER) begin
      ball_next      = '1;
      game_over_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_tennis_game.sv
// tb_tennis_game: directed game scenarios with a scoreboard of expected ball moves and step periods.
module tb_tennis_game;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left_btn = 1'b0;
  logic       right_btn = 1'b0;
  logic [7:0] ball;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       point;
  logic       game_over;

  typedef struct {
    logic [7:0] ball;
    int         period;
  } exp_t;

  exp_t       exp_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  int         last_chg = 0;
  int         point_cnt = 0;
  logic [7:0] prev_ball = 8'h80;

  tennis_game #(
    .N_LEDS(8), .DEBOUNCE_CYCLES(4), .TICK_DIV(10), .MIN_DIV(4),
    .SPEEDUP_STEP(4), .SCORE_W(4), .WIN_SCORE(2)
  ) dut (
    .clk(clk), .reset(reset), .left_btn(left_btn), .right_btn(right_btn),
    .ball(ball), .score_left(score_left), .score_right(score_right),
    .point(point), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expectBall(input logic [7:0] b, input int p);
    exp_t e;
    e.ball = b;
    e.period = p;
    exp_q.push_back(e);
  endtask

  task automatic expectRun(input logic [7:0] first, input int count, input bit to_right, input int p);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < count; i++) begin
      expectBall(b, p);
      b = to_right ? (b >> 1) : (b << 1);
    end
  endtask

  task automatic applyStimulus(input bit lft, input bit rgt, input int n);
    if (lft) left_btn = 1'b1;
    if (rgt) right_btn = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    left_btn = 1'b0;
    right_btn = 1'b0;
  endtask

  task automatic waitBall(input logic [7:0] v, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ball === v) break;
    end
    checkOutput("wait_ball", ball, v);
  endtask

  task automatic waitPoints(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (point_cnt >= n) break;
    end
    repeat (3) @(negedge clk);
    checkOutput("point_count", point_cnt, n);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ball"}, ball, 8'h80);
    checkOutput({tag, "_score_l"}, score_left, 0);
    checkOutput({tag, "_score_r"}, score_right, 0);
    checkOutput({tag, "_game_over"}, game_over, 0);
    checkOutput({tag, "_point"}, point, 0);
  endtask

  // Scoreboard monitor: every ball change must match the next expected position and step period
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      prev_ball = ball;
      last_chg = cyc;
    end else if (ball !== prev_ball) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_move", ball, prev_ball);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("ball", ball, e.ball);
        if (e.period != 0) checkOutput("period", cyc - last_chg, e.period);
      end
      prev_ball = ball;
      last_chg = cyc;
    end
    if (point === 1'b1) point_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #10;
    checkResetState("reset");
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Glitch shorter than the debounce window must not serve
    applyStimulus(1'b1, 1'b0, 3);
    repeat (20) @(negedge clk);
    checkOutput("glitch_ball", ball, 8'h80);

    // Left serve, ball walks to the right end at the serve speed
    expectBall(8'h40, 0);
    expectRun(8'h20, 6, 1'b1, 10);
    applyStimulus(1'b1, 1'b0, 6);
    waitBall(8'h01, 200);

    // Right returns at the end: bounce at old period, then 6-cycle steps
    expectBall(8'h02, 10);
    expectRun(8'h04, 5, 1'b0, 6);
    expectBall(8'h80, 6);
    applyStimulus(1'b0, 1'b1, 8);
    waitBall(8'h40, 200);

    // Left returns (pulse lands while ball sits at the left end), then 4-cycle steps
    expectBall(8'h40, 6);
    expectRun(8'h20, 5, 1'b1, 4);
    applyStimulus(1'b1, 1'b0, 8);
    waitBall(8'h02, 200);

    // Third return stays at the MIN_DIV clamp; then left misses and right scores
    expectBall(8'h01, 4);
    expectBall(8'h02, 4);
    expectRun(8'h04, 6, 1'b0, 4);
    expectBall(8'h01, 4);
    applyStimulus(1'b0, 1'b1, 8);
    waitPoints(1, 300);
    checkOutput("miss1_score_r", score_right, 1);
    checkOutput("miss1_score_l", score_left, 0);
    checkOutput("miss1_ball", ball, 8'h01);
    checkOutput("miss1_game_over", game_over, 0);

    // Right serves at restored speed, left returns
    expectBall(8'h02, 0);
    expectRun(8'h04, 6, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 8);
    waitBall(8'h80, 200);
    expectBall(8'h40, 10);
    expectRun(8'h20, 4, 1'b1, 6);
    applyStimulus(1'b1, 1'b0, 8);
    waitBall(8'h04, 200);

    // Early right press away from the end is dropped, so left scores
    expectRun(8'h02, 2, 1'b1, 6);
    expectBall(8'h80, 6);
    applyStimulus(1'b0, 1'b1, 8);
    waitPoints(2, 300);
    checkOutput("early_score_l", score_left, 1);
    checkOutput("early_score_r", score_right, 1);
    checkOutput("early_ball", ball, 8'h80);

    // Left serves again, right misses, left reaches the winning score
    expectBall(8'h40, 0);
    expectRun(8'h20, 6, 1'b1, 10);
    expectBall(8'hFF, 10);
    applyStimulus(1'b1, 1'b0, 8);
    waitPoints(3, 300);
    checkOutput("over_score_l", score_left, 2);
    checkOutput("over_score_r", score_right, 1);
    checkOutput("over_game_over", game_over, 1);
    checkOutput("over_ball", ball, 8'hFF);

    // Presses are ignored once the game is over
    applyStimulus(1'b1, 1'b1, 8);
    repeat (30) @(negedge clk);
    checkOutput("over_hold_ball", ball, 8'hFF);
    checkOutput("over_hold_score_l", score_left, 2);
    checkOutput("over_hold_game_over", game_over, 1);
    checkOutput("over_hold_points", point_cnt, 3);

    // Asynchronous reset out of OVER, checked before any clock edge
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkResetState("reset_over");
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Mid-rally asynchronous reset
    expectBall(8'h40, 0);
    expectBall(8'h20, 10);
    expectBall(8'h10, 10);
    applyStimulus(1'b1, 1'b0, 6);
    waitBall(8'h10, 200);
    #3 reset = 1'b0;
    #1;
    checkResetState("reset_rally");
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
